ps2_rx_controller: RTL and testbench

Sequences reception of PS/2 device-to-host frames into bytes for the logic-analyzer example designs.
- Resynchronizes ps2_clk/ps2_data and runs a frame state machine: start, 8 data bits LSB-first, odd parity, stop.
- Guards every frame with an inter-edge watchdog.
- Buffers good bytes in a small FIFO behind a valid/ready handshake and reports framing errors.

---
 rtl/ps2_rx_controller.sv | 197 +++++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_controller.sv
// PS/2 device-to-host receiver: synchronizer, frame FSM with inter-edge watchdog, byte FIFO.
// Optional ps2_clk stability filter is enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_rx_controller #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic [1:0] err_type,
  output logic       overflow,
  output logic       busy
);
  // state  | meaning
  // IDLE   | waiting for a start bit
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking the stop bit and resolving the frame
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, sdat_sync_q, sdat_sync_d;
  logic          prev_q, prev_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_type_q, err_type_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic sclk, sdat, lvl, fall, timeout, push, pop, full;

`ifdef PS2_RX_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;
`endif

  assign sclk = sclk_sync_q[SYNC_STAGES-1];
  assign sdat = sdat_sync_q[SYNC_STAGES-1];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], ps2_data};
`ifdef PS2_RX_GLITCH_FILTER_EN
    // Filtered level follows the raw level only after 16 consecutive differing cycles
    filt_d = filt_q;
    fcnt_d = 4'd0;
    if (sclk != filt_q) begin
      if (fcnt_q == 4'd15) filt_d = sclk;
      else                 fcnt_d = fcnt_q + 4'd1;
    end
    lvl = filt_q;
`else
    lvl = sclk;
`endif
    fall   = prev_q & ~lvl;
    prev_d = lvl;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    frame_err_d = 1'b0;
    err_type_d  = err_type_q;
    overflow_d  = 1'b0;
    push        = 1'b0;

    wdog_d  = (state_q == IDLE || fall) ? '0 : wdog_q + WW'(1);
    // Expiry lands on the edge where the counter would reach TIMEOUT_CYCLES-1
    timeout = (state_q != IDLE) && !fall && (wdog_q == WD_LAST);

    case (state_q)
      IDLE: if (fall && !sdat) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
      end
      DATA: if (fall) begin
        shift_d[bit_cnt_q] = sdat;
        bit_cnt_d          = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = sdat;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (!sdat) begin
          frame_err_d = 1'b1;
          err_type_d  = 2'b10;
        end else if (^{shift_q, par_q} != 1'b1) begin
          frame_err_d = 1'b1;
          err_type_d  = 2'b01;
        end else begin
          push = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_type_d  = 2'b11;
    end
    busy_d = (state_d != IDLE);

    full     = (count_q == FULL_CNT);
    pop      = (count_q != '0) && ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      count_d         = count_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_d - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '1;
      sdat_sync_q <= '1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      wdog_q      <= '0;
      frame_err_q <= 1'b0;
      err_type_q  <= 2'b00;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_q       <= '{default: 8'h00};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef PS2_RX_GLITCH_FILTER_EN
      filt_q      <= 1'b1;
      fcnt_q      <= 4'd0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sdat_sync_q <= sdat_sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wdog_q      <= wdog_d;
      frame_err_q <= frame_err_d;
      err_type_q  <= err_type_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef PS2_RX_GLITCH_FILTER_EN
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
`endif
    end
  end

  assign data      = mem_q[rd_ptr_q];
  assign valid     = (count_q != '0);
  assign frame_err = frame_err_q;
  assign err_type  = err_type_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_ps2_rx_controller.sv
// Bench for ps2_rx_controller: directed frame scenarios plus randomized frames against a byte/error model.
`timescale 1ns/1ps
module tb_ps2_rx_controller;
  localparam int SYNC  = 2;
  localparam int TMO   = 200;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;
`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 1 + 16;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overflow, busy;
  logic [1:0] err_type;

  int total = 0, bad = 0;
  int n_err = 0, n_ovf = 0;
  logic [7:0] got[$];

  ps2_rx_controller #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .ready(ready), .frame_err(frame_err),
    .err_type(err_type), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event monitor: error/overflow pulses and accepted bytes
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_err++;
      if (overflow) n_ovf++;
      if (valid && ready) got.push_back(data);
    end
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic odd_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      cyc(5); ps2_clk = 1'b0; cyc(5); ps2_clk = 1'b1; cyc(HALF - 10);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stp, glitch);
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(4);
    total++; if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", valid); bad++; end
    total++; if (data !== 8'h00) begin $display("FAIL reset_data: got %h want 00", data); bad++; end
    total++; if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err: got %b want 0", frame_err); bad++; end
    total++; if (err_type !== 2'b00) begin $display("FAIL reset_err_type: got %b want 00", err_type); bad++; end
    total++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow: got %b want 0", overflow); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); bad++; end
    rst = 1'b0;
    cyc(3);
    total++; if (busy !== 1'b0) begin $display("FAIL post_reset_busy: got %b want 0", busy); bad++; end
  endtask

  task automatic test_good_frame();
    int e0 = n_err, g0 = got.size();
    ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    total++; if (got.size() !== g0 + 1) begin $display("FAIL good_count: got %0d want %0d", got.size(), g0 + 1); bad++; end
    total++; if (got[g0] !== 8'h1C) begin $display("FAIL good_data: got %h want 1c", got[g0]); bad++; end
    total++; if (n_err !== e0) begin $display("FAIL good_no_err: got %0d want %0d", n_err, e0); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL good_busy: got %b want 0", busy); bad++; end
    total++; if (valid !== 1'b0) begin $display("FAIL good_drained: got %b want 0", valid); bad++; end
  endtask

  task automatic test_parity_err();
    int e0 = n_err, g0 = got.size();
    ready = 1'b1;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    total++; if (n_err !== e0 + 1) begin $display("FAIL par_pulse: got %0d want %0d", n_err, e0 + 1); bad++; end
    total++; if (err_type !== 2'b01) begin $display("FAIL par_type: got %b want 01", err_type); bad++; end
    total++; if (got.size() !== g0) begin $display("FAIL par_no_byte: got %0d want %0d", got.size(), g0); bad++; end
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
    total++; if (got.size() !== g0 + 1 || got[g0] !== 8'hF0) begin
      $display("FAIL par_next_byte: got %0d bytes want F0 as byte %0d", got.size(), g0); bad++; end
    total++; if (n_err !== e0 + 1) begin $display("FAIL par_next_no_err: got %0d want %0d", n_err, e0 + 1); bad++; end
  endtask

  task automatic test_stop_err();
    int e0 = n_err, g0 = got.size();
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    total++; if (n_err !== e0 + 1) begin $display("FAIL stop_pulse: got %0d want %0d", n_err, e0 + 1); bad++; end
    total++; if (err_type !== 2'b10) begin $display("FAIL stop_type: got %b want 10", err_type); bad++; end
    total++; if (got.size() !== g0) begin $display("FAIL stop_no_byte: got %0d want %0d", got.size(), g0); bad++; end
  endtask

  task automatic test_timeout();
    int k = 0;
    int g0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b0;
    while (frame_err !== 1'b1 && k < 2 * TMO + 100) begin
      cyc(1);
      k++;
      if (k == HALF) begin
        ps2_clk = 1'b1;
        total++; if (busy !== 1'b1) begin $display("FAIL tmo_busy_mid: got %b want 1", busy); bad++; end
      end
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    total++; if (k !== LAT + TMO - 1) begin $display("FAIL tmo_latency: got %0d cycles want %0d", k, LAT + TMO - 1); bad++; end
    total++; if (err_type !== 2'b11) begin $display("FAIL tmo_type: got %b want 11", err_type); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL tmo_busy: got %b want 0", busy); bad++; end
    cyc(2 * HALF);
    g0 = got.size();
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
    total++; if (got.size() !== g0 + 1 || got[g0] !== 8'h5A) begin
      $display("FAIL tmo_next_byte: got %0d bytes want 5A as byte %0d", got.size(), g0); bad++; end
  endtask

  task automatic test_overflow();
    logic [7:0] expq[$];
    int o0;
    ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      o0 = n_ovf;
      send_frame(8'(v), odd_par(8'(v)), 1'b1, 1'b0);
      if (expq.size() < DEPTH) begin
        expq.push_back(8'(v));
        total++; if (n_ovf !== o0) begin $display("FAIL ovf_early frame %0d: got %0d pulses want 0", v, n_ovf - o0); bad++; end
      end else begin
        total++; if (n_ovf !== o0 + 1) begin $display("FAIL ovf_pulse frame %0d: got %0d pulses want 1", v, n_ovf - o0); bad++; end
      end
    end
    ready = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      total++; if (valid !== 1'b1 || data !== expq[i]) begin
        $display("FAIL ovf_drain %0d: got valid=%b data=%h want valid=1 data=%h", i, valid, data, expq[i]); bad++; end
      cyc(1);
    end
    total++; if (valid !== 1'b0) begin $display("FAIL ovf_empty: got %b want 0", valid); bad++; end
  endtask

  task automatic test_reset_midframe();
    int e0 = n_err, g0;
    logic [7:0] b = 8'hA7;
    ready = 1'b1;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i], 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    total++; if (n_err !== e0) begin $display("FAIL rstmid_err: got %0d want %0d", n_err, e0); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", busy); bad++; end
    total++; if (valid !== 1'b0) begin $display("FAIL rstmid_valid: got %b want 0", valid); bad++; end
    cyc(2 * HALF);
    g0 = got.size();
    send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0);
    total++; if (got.size() !== g0 + 1 || got[g0] !== 8'h29) begin
      $display("FAIL rstmid_next_byte: got %0d bytes want 29 as byte %0d", got.size(), g0); bad++; end
    total++; if (n_err !== e0) begin $display("FAIL rstmid_next_err: got %0d want %0d", n_err, e0); bad++; end
  endtask

`ifdef PS2_RX_GLITCH_FILTER_EN
  task automatic test_glitch();
    int e0 = n_err, g0 = got.size();
    ready = 1'b1;
    send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b1);
    total++; if (got.size() !== g0 + 1 || got[g0] !== 8'h29) begin
      $display("FAIL glitch_byte: got %0d bytes want 29 as byte %0d", got.size(), g0); bad++; end
    total++; if (n_err !== e0) begin $display("FAIL glitch_err: got %0d want %0d", n_err, e0); bad++; end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    logic par, stp;
    logic [1:0] exp_type;
    int kind, e0, g0;
    ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 3);
      stp  = (kind != 3);
      par  = (kind == 3) ? 1'($urandom) : (odd_par(b) ^ (kind == 2));
      if (!stp)                 exp_type = 2'b10;
      else if (par != odd_par(b)) exp_type = 2'b01;
      else                      exp_type = 2'b00;
      e0 = n_err; g0 = got.size();
      send_frame(b, par, stp, 1'b0);
      if (exp_type != 2'b00) begin
        total++; if (n_err !== e0 + 1 || err_type !== exp_type || got.size() !== g0) begin
          $display("FAIL rand_err %0d: got pulses=%0d type=%b bytes=%0d want 1 %b 0", n, n_err - e0, err_type, got.size() - g0, exp_type); bad++; end
      end else begin
        total++; if (n_err !== e0 || got.size() !== g0 + 1 || got[g0] !== b) begin
          $display("FAIL rand_byte %0d: got pulses=%0d bytes=%0d want 0 1 byte %h", n, n_err - e0, got.size() - g0, b); bad++; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_overflow();
    test_reset_midframe();
`ifdef PS2_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
